// File: rtl/atm_keypad_session.sv
// Keypad-driven session initiator for the ATM controller: collects account, PIN, operation, amount
// and new PIN, issues the request and strobes the result. Optional macro: SESSION_LOCKOUT_EN.
module atm_keypad_session #(
  parameter int          AMT_DIGITS    = 6,
  parameter int          TIMEOUT_CYC   = 1024,
  parameter logic [3:0]  IDLE_ACC      = 4'hF,
  parameter logic [2:0]  IDLE_OP       = 3'h7,
`ifdef SESSION_LOCKOUT_EN
  parameter int          MAX_FAILS     = 3,
`endif
  parameter logic [2:0]  ST_WAITING    = 3'd0,
  parameter logic [2:0]  OP_BALANCE    = 3'd1,
  parameter logic [2:0]  OP_WITHDRAW   = 3'd2,
  parameter logic [2:0]  OP_DEPOSIT    = 3'd3,
  parameter logic [2:0]  OP_CHANGE_PIN = 3'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        lang_sel,
  input  logic [2:0]  atm_state,
  input  logic        atm_success,
  input  logic [31:0] atm_balance,
  output logic [3:0]  acc_num,
  output logic [15:0] pin,
  output logic [15:0] newPin,
  output logic [31:0] amount,
  output logic [2:0]  operation,
  output logic        language,
  output logic [2:0]  prompt,
  output logic        busy,
  output logic        rsp_valid,
  output logic        rsp_success,
  output logic        rsp_timeout,
  output logic [31:0] rsp_balance
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_PIN, S_GET_OP, S_GET_AMT, S_GET_NEWPIN, S_ISSUE, S_WAIT_RSP, S_LOCKED
  } state_t;

  localparam int AW = $clog2(AMT_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1) + 1;

  state_t        state_q, state_d;
  logic [3:0]    acc_q, acc_d;
  logic [15:0]   pin_q, pin_d, newpin_q, newpin_d;
  logic [31:0]   amount_q, amount_d;
  logic [2:0]    op_sel_q, op_sel_d, operation_q, operation_d, prompt_q, prompt_d;
  logic          lang_q, lang_d, busy_q, busy_d, seen_q, seen_d;
  logic [2:0]    pcnt_q, pcnt_d;
  logic [AW-1:0] acnt_q, acnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rsp_valid_q, rsp_valid_d, rsp_success_q, rsp_success_d;
  logic          rsp_timeout_q, rsp_timeout_d;
  logic [31:0]   rsp_balance_q, rsp_balance_d;
  logic          go_idle;
  logic          is_digit, k_enter, k_cancel, k_clear;
`ifdef SESSION_LOCKOUT_EN
  localparam int FW = $clog2(MAX_FAILS + 1);
  logic [FW-1:0] fail_q, fail_d;
`endif

  assign is_digit = key_valid && (key_code <= 4'd9);
  assign k_enter  = key_valid && (key_code == 4'hA);
  assign k_cancel = key_valid && (key_code == 4'hB);
  assign k_clear  = key_valid && (key_code == 4'hC);

  function automatic logic [2:0] prompt_of(input state_t s);
    case (s)
      S_IDLE:       prompt_of = 3'd0;
      S_GET_PIN:    prompt_of = 3'd2;
      S_GET_OP:     prompt_of = 3'd3;
      S_GET_AMT:    prompt_of = 3'd4;
      S_GET_NEWPIN: prompt_of = 3'd5;
      S_LOCKED:     prompt_of = 3'd7;
      default:      prompt_of = 3'd6;
    endcase
  endfunction

  always_comb begin
    state_d       = state_q;
    acc_d         = acc_q;
    pin_d         = pin_q;
    newpin_d      = newpin_q;
    amount_d      = amount_q;
    op_sel_d      = op_sel_q;
    lang_d        = lang_q;
    pcnt_d        = pcnt_q;
    acnt_d        = acnt_q;
    seen_d        = seen_q;
    tmo_d         = tmo_q;
    rsp_valid_d   = 1'b0;
    rsp_success_d = rsp_success_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_balance_d = rsp_balance_q;
    go_idle       = 1'b0;
`ifdef SESSION_LOCKOUT_EN
    fail_d        = fail_q;
`endif
    case (state_q)
      S_IDLE: begin
        tmo_d  = '0;
        seen_d = 1'b0;
        if (key_valid) lang_d = lang_sel;
        if (is_digit) begin
          acc_d   = key_code;
          pcnt_d  = '0;
          state_d = S_GET_PIN;
        end
      end
      S_GET_PIN, S_GET_NEWPIN: begin
        if (k_cancel) go_idle = 1'b1;
        else if (k_clear) begin
          if (state_q == S_GET_PIN) pin_d = '0; else newpin_d = '0;
          pcnt_d = '0;
        end else if (is_digit && pcnt_q < 3'd4) begin
          if (state_q == S_GET_PIN) pin_d = {pin_q[11:0], key_code};
          else newpin_d = {newpin_q[11:0], key_code};
          pcnt_d = pcnt_q + 3'd1;
        end else if (k_enter && pcnt_q == 3'd4) begin
          state_d = (state_q == S_GET_PIN) ? S_GET_OP : S_ISSUE;
          pcnt_d  = '0;
        end
      end
      S_GET_OP: begin
        if (k_cancel) go_idle = 1'b1;
        else if (is_digit) begin
          case (key_code)
            4'd1: begin op_sel_d = OP_BALANCE;    state_d = S_ISSUE;      end
            4'd2: begin op_sel_d = OP_WITHDRAW;   state_d = S_GET_AMT;    end
            4'd3: begin op_sel_d = OP_DEPOSIT;    state_d = S_GET_AMT;    end
            4'd4: begin op_sel_d = OP_CHANGE_PIN; state_d = S_GET_NEWPIN; end
            4'd5: go_idle = 1'b1;
            default: ;
          endcase
        end
      end
      S_GET_AMT: begin
        if (k_cancel) go_idle = 1'b1;
        else if (k_clear) begin
          amount_d = '0;
          acnt_d   = '0;
        end else if (is_digit && acnt_q < AW'(AMT_DIGITS)) begin
          amount_d = amount_q * 32'd10 + {28'd0, key_code};
          acnt_d   = acnt_q + 1'b1;
        end else if (k_enter && amount_q != 32'd0) begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = TW'(1);
        seen_d  = 1'b0;
        state_d = S_WAIT_RSP;
      end
      S_WAIT_RSP: begin
        tmo_d = tmo_q + 1'b1;
        if (atm_state != ST_WAITING) seen_d = 1'b1;
        // Only a return to WAITING after the controller has left it marks completion.
        if (seen_q && atm_state == ST_WAITING) begin
          rsp_valid_d   = 1'b1;
          rsp_success_d = atm_success;
          rsp_timeout_d = 1'b0;
          rsp_balance_d = atm_balance;
          go_idle       = 1'b1;
        end else if (tmo_q >= TW'(TIMEOUT_CYC)) begin
          rsp_valid_d   = 1'b1;
          rsp_success_d = 1'b0;
          rsp_timeout_d = 1'b1;
          go_idle       = 1'b1;
        end
      end
      default: ;
    endcase

    if (go_idle) begin
      state_d  = S_IDLE;
      acc_d    = IDLE_ACC;
      pin_d    = '0;
      newpin_d = '0;
      amount_d = '0;
      op_sel_d = IDLE_OP;
      pcnt_d   = '0;
      acnt_d   = '0;
    end
`ifdef SESSION_LOCKOUT_EN
    if (rsp_valid_d) begin
      fail_d = rsp_success_d ? '0 : fail_q + 1'b1;
      if (fail_d >= FW'(MAX_FAILS)) state_d = S_LOCKED;
    end
`endif
    operation_d = (state_d == S_ISSUE || state_d == S_WAIT_RSP) ? op_sel_d : IDLE_OP;
    busy_d      = (state_d == S_ISSUE || state_d == S_WAIT_RSP);
    prompt_d    = prompt_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      acc_q         <= IDLE_ACC;
      pin_q         <= '0;
      newpin_q      <= '0;
      amount_q      <= '0;
      op_sel_q      <= IDLE_OP;
      operation_q   <= IDLE_OP;
      lang_q        <= 1'b0;
      prompt_q      <= 3'd0;
      busy_q        <= 1'b0;
      seen_q        <= 1'b0;
      pcnt_q        <= '0;
      acnt_q        <= '0;
      tmo_q         <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_success_q <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_balance_q <= '0;
`ifdef SESSION_LOCKOUT_EN
      fail_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      acc_q         <= acc_d;
      pin_q         <= pin_d;
      newpin_q      <= newpin_d;
      amount_q      <= amount_d;
      op_sel_q      <= op_sel_d;
      operation_q   <= operation_d;
      lang_q        <= lang_d;
      prompt_q      <= prompt_d;
      busy_q        <= busy_d;
      seen_q        <= seen_d;
      pcnt_q        <= pcnt_d;
      acnt_q        <= acnt_d;
      tmo_q         <= tmo_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_success_q <= rsp_success_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_balance_q <= rsp_balance_d;
`ifdef SESSION_LOCKOUT_EN
      fail_q        <= fail_d;
`endif
    end
  end

  assign acc_num     = acc_q;
  assign pin         = pin_q;
  assign newPin      = newpin_q;
  assign amount      = amount_q;
  assign operation   = operation_q;
  assign language    = lang_q;
  assign prompt      = prompt_q;
  assign busy        = busy_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_success = rsp_success_q;
  assign rsp_timeout = rsp_timeout_q;
  assign rsp_balance = rsp_balance_q;

endmodule

// File: tb/tb_atm_keypad_session.sv
// Directed bench for atm_keypad_session: keypad sessions against a scripted controller,
// responses scored from an expected queue. Honours SESSION_LOCKOUT_EN.
module tb_atm_keypad_session;

  localparam logic [2:0] WAITING = 3'd0;
  localparam logic [2:0] ATM_BUSY = 3'd2;
  localparam logic [2:0] OP_BAL = 3'd1, OP_WD = 3'd2;
  localparam logic [3:0] K_ENT = 4'hA, K_CAN = 4'hB, K_CLR = 4'hC;
  localparam int TMO = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd0;
  logic        lang_sel = 1'b0;
  logic [2:0]  atm_state = WAITING;
  logic        atm_success = 1'b0;
  logic [31:0] atm_balance = 32'd0;
  logic [3:0]  acc_num;
  logic [15:0] pin, newPin;
  logic [31:0] amount, rsp_balance;
  logic [2:0]  operation, prompt;
  logic        language, busy, rsp_valid, rsp_success, rsp_timeout;

  int n_checks = 0, n_pass = 0, n_fail = 0, rsp_cnt = 0;
  logic [33:0] exp_q[$];

  atm_keypad_session dut (
    .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code), .lang_sel(lang_sel),
    .atm_state(atm_state), .atm_success(atm_success), .atm_balance(atm_balance),
    .acc_num(acc_num), .pin(pin), .newPin(newPin), .amount(amount), .operation(operation),
    .language(language), .prompt(prompt), .busy(busy), .rsp_valid(rsp_valid),
    .rsp_success(rsp_success), .rsp_timeout(rsp_timeout), .rsp_balance(rsp_balance)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every response strobe pops one expected {timeout, success, balance}.
  always @(negedge clk) begin
    if (rst === 1'b1 && rsp_valid === 1'b1) begin
      logic [33:0] e;
      rsp_cnt++;
      if (exp_q.size() == 0) chk("unexpected_rsp", 32'd1, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("rsp_timeout", {31'd0, rsp_timeout}, {31'd0, e[33]});
        chk("rsp_success", {31'd0, rsp_success}, {31'd0, e[32]});
        if (!e[33]) chk("rsp_balance", rsp_balance, e[31:0]);
        chk("rsp_acc_idle", {28'd0, acc_num}, 32'hF);
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(posedge clk); #1;
    key_valid = 1'b1; key_code = k;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic start_session(input logic [3:0] acc, input logic [15:0] p);
    press(acc);
    for (int i = 3; i >= 0; i--) press(p[i*4 +: 4]);
    press(K_ENT);
  endtask

  task automatic wait_rsp(input int budget);
    int start, n;
    start = rsp_cnt; n = 0;
    while (rsp_cnt == start && n < budget) begin
      @(negedge clk); n++;
    end
    chk("rsp_arrived", {31'd0, rsp_cnt != start}, 32'd1);
  endtask

  task automatic atm_complete(input logic s, input logic [31:0] b);
    @(posedge clk); #1 atm_state = ATM_BUSY;
    repeat (3) @(posedge clk);
    #1;
    atm_success = s; atm_balance = b;
    exp_q.push_back({1'b0, s, b});
    atm_state = WAITING;
    wait_rsp(20);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_acc"}, {28'd0, acc_num}, 32'hF);
    chk({tag, "_op"}, {29'd0, operation}, 32'h7);
    chk({tag, "_pin"}, {16'd0, pin}, 32'd0);
    chk({tag, "_newpin"}, {16'd0, newPin}, 32'd0);
    chk({tag, "_amount"}, amount, 32'd0);
    chk({tag, "_prompt"}, {29'd0, prompt}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved;
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("reset_lang", {31'd0, language}, 32'd0);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_rsp_bal", rsp_balance, 32'd0);
    rst = 1'b1;

    // Balance enquiry
    lang_sel = 1'b1;
    start_session(4'd3, 16'h1234);
    chk("bal_prompt_op", {29'd0, prompt}, 32'd3);
    chk("bal_acc", {28'd0, acc_num}, 32'd3);
    chk("bal_pin", {16'd0, pin}, 32'h1234);
    press(4'd1);
    chk("bal_issue_busy", {31'd0, busy}, 32'd1);
    chk("bal_issue_op", {29'd0, operation}, {29'd0, OP_BAL});
    chk("bal_issue_lang", {31'd0, language}, 32'd1);
    chk("bal_issue_prompt", {29'd0, prompt}, 32'd6);
    atm_complete(1'b1, 32'd4000);
    @(negedge clk);
    chk("bal_strobe_one_cycle", {31'd0, rsp_valid}, 32'd0);
    chk_idle("bal_done");
    lang_sel = 1'b0;

    // Withdraw 500, request held through the wait
    start_session(4'd0, 16'h5678);
    press(4'd2);
    chk("wd_prompt_amt", {29'd0, prompt}, 32'd4);
    press(4'd5); press(4'd0); press(4'd0);
    chk("wd_amount_entry", amount, 32'd500);
    press(K_ENT);
    @(posedge clk); #1 atm_state = ATM_BUSY;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("wd_hold_amount", amount, 32'd500);
      chk("wd_hold_op", {29'd0, operation}, {29'd0, OP_WD});
      chk("wd_hold_acc", {28'd0, acc_num}, 32'd0);
      chk("wd_hold_pin", {16'd0, pin}, 32'h5678);
    end
    atm_success = 1'b1; atm_balance = 32'd3500;
    exp_q.push_back({1'b0, 1'b1, 32'd3500});
    atm_state = WAITING;
    wait_rsp(20);

    // Deposit amount limits, CLEAR and CANCEL
    saved = rsp_cnt;
    start_session(4'd7, 16'h1111);
    press(4'd3);
    press(K_ENT);
    chk("amt_zero_enter_ignored", {29'd0, prompt}, 32'd4);
    for (int d = 1; d <= 9; d++) press(4'(d));
    chk("amt_six_digits", amount, 32'd123456);
    press(K_CLR);
    chk("amt_clear", amount, 32'd0);
    press(4'd4); press(4'd2);
    chk("amt_after_clear", amount, 32'd42);
    press(K_CAN);
    chk_idle("amt_cancel");
    repeat (3) @(posedge clk);
    chk("amt_cancel_no_rsp", rsp_cnt, saved);

    // Timeout: controller never returns to WAITING
    start_session(4'd2, 16'h9999);
    press(4'd1);
    atm_state = ATM_BUSY;
    exp_q.push_back({1'b1, 1'b0, 32'd0});
    wait_rsp(TMO + 20);
    atm_state = WAITING;
    chk_idle("tmo_done");

    // PIN entry rules, change-PIN then CANCEL
    saved = rsp_cnt;
    press(4'd4);
    press(4'd4); press(4'd3); press(4'd2);
    press(K_ENT);
    chk("pin_short_enter", {29'd0, prompt}, 32'd2);
    press(4'd1); press(4'd9);
    chk("pin_fifth_ignored", {16'd0, pin}, 32'h4321);
    press(K_ENT);
    press(4'd4);
    chk("np_prompt", {29'd0, prompt}, 32'd5);
    press(4'd1); press(4'd2);
    chk("np_partial", {16'd0, newPin}, 32'h0012);
    press(K_CLR);
    chk("np_clear", {16'd0, newPin}, 32'd0);
    press(4'd5); press(4'd6);
    press(K_CAN);
    chk_idle("np_cancel");

    // Exit from operation menu
    start_session(4'd8, 16'h2468);
    press(4'd5);
    chk_idle("op_exit");
    repeat (3) @(posedge clk);
    chk("no_rsp_after_cancels", rsp_cnt, saved);

    // Reset in the middle of a wait
    saved = rsp_cnt;
    start_session(4'd6, 16'h1357);
    press(4'd1);
    @(posedge clk); #1 atm_state = ATM_BUSY;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    chk_idle("midrst");
    chk("midrst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrst_rsp_bal", rsp_balance, 32'd0);
    rst = 1'b1; atm_state = WAITING;
    repeat (3) @(posedge clk);
    chk("midrst_no_rsp", rsp_cnt, saved);

    // Three failed sessions
    for (int s = 0; s < 3; s++) begin
      start_session(4'(s + 1), 16'h0000);
      press(4'd1);
      atm_complete(1'b0, 32'd77);
    end
    @(negedge clk);
`ifdef SESSION_LOCKOUT_EN
    chk("lock_prompt", {29'd0, prompt}, 32'd7);
    press(4'd1);
    chk("lock_key_ignored_prompt", {29'd0, prompt}, 32'd7);
    chk("lock_key_ignored_acc", {28'd0, acc_num}, 32'hF);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    chk("lock_reset_prompt", {29'd0, prompt}, 32'd0);
`else
    chk("nolock_prompt", {29'd0, prompt}, 32'd0);
    press(4'd1);
    chk("nolock_new_session", {29'd0, prompt}, 32'd2);
    chk("nolock_acc", {28'd0, acc_num}, 32'd1);
    press(K_CAN);
`endif

    repeat (3) @(posedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("total_rsp", rsp_cnt, 32'd6);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
